// File: rtl/uart_tx_periph_pkg.sv
// Shared constants for the UART transmit peripheral: register map, field
// positions and transmitter state encoding.
package uart_tx_periph_pkg;

  localparam logic [31:0] ADDR_TXDATA = 32'h4000_0018;
  localparam logic [31:0] ADDR_STATUS = 32'h4000_001C;
  localparam logic [31:0] ADDR_CTRL   = 32'h4000_0020;

  localparam int STATUS_FULL_BIT  = 0;
  localparam int STATUS_EMPTY_BIT = 1;
  localparam int STATUS_BUSY_BIT  = 2;
  localparam int STATUS_OVF_BIT   = 3;
  localparam int STATUS_COUNT_LSB = 4;

  localparam int CTRL_IRQ_EN_BIT  = 0;
  localparam int CTRL_OVF_CLR_BIT = 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_tx_periph_fifo.sv
// Synchronous byte FIFO feeding the transmitter; depth is 2^DEPTH_BIT and the
// head entry is presented combinationally on dout.
module tx_fifo #(
  parameter int DEPTH_BIT = 3,
  parameter int WIDTH     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic                 pop,
  input  logic [WIDTH-1:0]     din,
  output logic [WIDTH-1:0]     dout,
  output logic                 full,
  output logic                 empty,
  output logic [DEPTH_BIT:0]   count
);

  localparam int DEPTH = 1 << DEPTH_BIT;
  typedef logic [DEPTH_BIT-1:0] ptr_t;
  typedef logic [DEPTH_BIT:0]   cnt_t;

  logic [WIDTH-1:0] mem_r [DEPTH];
  ptr_t wr_ptr_r;
  ptr_t rd_ptr_r;
  cnt_t count_r;
  logic push_ok_s;
  logic pop_ok_s;

  assign full  = (count_r == cnt_t'(DEPTH));
  assign empty = (count_r == cnt_t'(0));
  assign count = count_r;
  assign dout  = mem_r[rd_ptr_r];

  // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
  assign push_ok_s = push & (~full | pop);
  assign pop_ok_s  = pop & ~empty;

  // Storage array; occupancy gates every read so it needs no reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_r[wr_ptr_r] <= din;
  end

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= ptr_t'(0);
      rd_ptr_r <= ptr_t'(0);
      count_r  <= cnt_t'(0);
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + ptr_t'(1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + ptr_t'(1);
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + cnt_t'(1);
        2'b01:   count_r <= count_r - cnt_t'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO, sticky overflow flag and
// a transmit-complete level interrupt.
module uart_tx_periph
  import uart_tx_periph_pkg::*;
#(
  parameter int CLKS_PER_BIT   = 10417,
  parameter int FIFO_DEPTH_BIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        Tx_Serial,
  output logic        tx_irq
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t BIT_RELOAD = cnt_t'(CLKS_PER_BIT - 1);

  tx_state_e state_r, state_s;
  cnt_t bit_cnt_r, bit_cnt_s;
  logic [2:0] bit_idx_r, bit_idx_s;
  logic [7:0] shift_r, shift_s;
  logic tx_r, tx_s;
  logic pop_s;
  logic irq_r, irq_en_r, ovf_r;
  logic push_s, wr_ctrl_s;
  logic [7:0] fifo_dout_s;
  logic fifo_full_s, fifo_empty_s;
  logic [FIFO_DEPTH_BIT:0] fifo_count_s;
  logic [31:0] status_s, ctrl_s;
  logic unused_s;

  assign push_s    = MemWrite & (address == ADDR_TXDATA);
  assign wr_ctrl_s = MemWrite & (address == ADDR_CTRL);
  assign unused_s  = ^write_data[31:8] ^ ^write_data[7:2];
  assign Tx_Serial = tx_r;
  assign tx_irq    = irq_r;

  tx_fifo #(.DEPTH_BIT(FIFO_DEPTH_BIT), .WIDTH(8)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .pop   (pop_s),
    .din   (write_data[7:0]),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  // Transmitter state and bit-timing registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= S_IDLE;
      bit_cnt_r <= cnt_t'(0);
      bit_idx_r <= 3'd0;
      shift_r   <= 8'd0;
      tx_r      <= 1'b1;
    end else begin
      state_r   <= state_s;
      bit_cnt_r <= bit_cnt_s;
      bit_idx_r <= bit_idx_s;
      shift_r   <= shift_s;
      tx_r      <= tx_s;
    end
  end

  // Next-state logic; the line level is computed one cycle ahead so Tx_Serial is a flop.
  always_comb begin
    state_s   = state_r;
    bit_cnt_s = bit_cnt_r;
    bit_idx_s = bit_idx_r;
    shift_s   = shift_r;
    tx_s      = tx_r;
    pop_s     = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (!fifo_empty_s) begin
          pop_s     = 1'b1;
          state_s   = S_START;
          bit_cnt_s = BIT_RELOAD;
          shift_s   = fifo_dout_s;
          tx_s      = 1'b0;
        end else begin
          tx_s = 1'b1;
        end
      end
      S_START: begin
        if (bit_cnt_r == cnt_t'(0)) begin
          state_s   = S_DATA;
          bit_cnt_s = BIT_RELOAD;
          bit_idx_s = 3'd0;
          tx_s      = shift_r[0];
        end else begin
          bit_cnt_s = bit_cnt_r - cnt_t'(1);
        end
      end
      S_DATA: begin
        if (bit_cnt_r == cnt_t'(0)) begin
          bit_cnt_s = BIT_RELOAD;
          if (bit_idx_r == 3'd7) begin
            state_s = S_STOP;
            tx_s    = 1'b1;
          end else begin
            bit_idx_s = bit_idx_r + 3'd1;
            shift_s   = {1'b0, shift_r[7:1]};
            tx_s      = shift_r[1];
          end
        end else begin
          bit_cnt_s = bit_cnt_r - cnt_t'(1);
        end
      end
      S_STOP: begin
        if (bit_cnt_r == cnt_t'(0)) begin
          if (!fifo_empty_s) begin
            pop_s     = 1'b1;
            state_s   = S_START;
            bit_cnt_s = BIT_RELOAD;
            shift_s   = fifo_dout_s;
            tx_s      = 1'b0;
          end else begin
            state_s = S_IDLE;
            tx_s    = 1'b1;
          end
        end else begin
          bit_cnt_s = bit_cnt_r - cnt_t'(1);
        end
      end
      default: begin
        state_s = S_IDLE;
        tx_s    = 1'b1;
      end
    endcase
  end

  // Control register, sticky overflow flag and registered interrupt.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_en_r <= 1'b0;
      ovf_r    <= 1'b0;
      irq_r    <= 1'b0;
    end else begin
      irq_r <= irq_en_r & fifo_empty_s & (state_r == S_IDLE);
      if (wr_ctrl_s) begin
        irq_en_r <= write_data[CTRL_IRQ_EN_BIT];
        if (write_data[CTRL_OVF_CLR_BIT]) ovf_r <= 1'b0;
      end else if (push_s & fifo_full_s & ~pop_s) begin
        ovf_r <= 1'b1;
      end
    end
  end

  // Register images as seen by the CPU.
  always_comb begin
    status_s = 32'd0;
    status_s[STATUS_FULL_BIT]  = fifo_full_s;
    status_s[STATUS_EMPTY_BIT] = fifo_empty_s;
    status_s[STATUS_BUSY_BIT]  = (state_r != S_IDLE);
    status_s[STATUS_OVF_BIT]   = ovf_r;
    status_s[STATUS_COUNT_LSB +: FIFO_DEPTH_BIT+1] = fifo_count_s;
    ctrl_s = 32'd0;
    ctrl_s[CTRL_IRQ_EN_BIT] = irq_en_r;
  end

  // Read mux; TXDATA is write-only and reads as zero.
  always_comb begin
    read_data = 32'd0;
    if (MemRead) begin
      case (address)
        ADDR_STATUS: read_data = status_s;
        ADDR_CTRL:   read_data = ctrl_s;
        default:     read_data = 32'd0;
      endcase
    end else begin
      read_data = 32'd0;
    end
  end

endmodule
